median_frame_scheduler: RTL

Frame-level controller placed in front of the 5x5 median pipeline (receiver → processing → transmitter). It latches the image geometry at frame boundaries and gates the slave AXI4-Stream input. It tracks column/row position, checks tuser/tlast framing, and injects the flush beats the line-buffered kernel needs to drain the last rows. It also reports frame completion and framing errors to software-visible status.

---
 rtl/median_sched_pkg.sv | 35 +++
 rtl/median_frame_position.sv | 75 +++++++
 rtl/median_frame_scheduler.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/median_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : median_sched_pkg
//  Description : Shared types, constants and helpers for the median filter
//                frame scheduler (state encoding, kernel half-size, flush
//                beat count).
//  Revision    : 1.0 - initial release
// ============================================================================
package median_sched_pkg;

    localparam int DIM_WIDTH_DEF   = 13;
    localparam int FLUSH_WIDTH_DEF = 16;
    localparam int KERNEL_SIZE_DEF = 5;
    localparam int HALF            = KERNEL_SIZE_DEF / 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_RUN      = 2'd2,
        ST_FLUSH    = 2'd3
    } sched_state_t;

    // Number of zero beats the line-buffered kernel needs to push the last
    // HALF rows (plus HALF pixels of the following row) out of its window.
    function automatic logic [FLUSH_WIDTH_DEF-1:0] flush_beats(
        input logic [31:0] width,
        input int          half = HALF
    );
        logic [31:0] total;
        total = 32'(half) * width + 32'(half);
        return total[FLUSH_WIDTH_DEF-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/median_frame_position.sv
`default_nettype none
// ============================================================================
//  Module      : median_frame_position
//  Description : Column/row tracker for accepted image beats. Checks the
//                upstream tlast/tuser framing against the latched geometry.
//  Ports       : clk, rst         - clock, synchronous active-high reset
//                beat             - an image beat is forwarded this cycle
//                in_frame         - scheduler is in the RUN state
//                tuser, tlast     - framing sidebands of the beat
//                img_width/height - latched geometry
//                eol, eof         - row end / frame end on this beat
//                err_early/late/sof - single-cycle framing error pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module median_frame_position
    import median_sched_pkg::*;
#(
    parameter int DIM_WIDTH = DIM_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 beat,
    input  logic                 in_frame,
    input  logic                 tuser,
    input  logic                 tlast,
    input  logic [DIM_WIDTH-1:0] img_width,
    input  logic [DIM_WIDTH-1:0] img_height,
    output logic                 eol,
    output logic                 eof,
    output logic                 err_early,
    output logic                 err_late,
    output logic                 err_sof
);

    logic [DIM_WIDTH-1:0] r_col;
    logic [DIM_WIDTH-1:0] r_row;
    logic                 w_last_col;
    logic                 w_last_row;
    logic                 w_restart;
    logic                 w_row_end;

    assign w_last_col = (r_col == img_width  - DIM_WIDTH'(1));
    assign w_last_row = (r_row == img_height - DIM_WIDTH'(1));

    // A tuser beat always restarts the frame and overrides any tlast check.
    assign w_restart  = beat & tuser;
    // A row ends either on tlast or on reaching the last column, whichever
    // comes first; a mismatch between the two is reported but still ends it.
    assign w_row_end  = beat & ~tuser & (tlast | w_last_col);

    assign eol       = w_row_end;
    // Closing the frame on any row end in the last row (not only the exact
    // last column) keeps an early tlast there from running past the frame.
    assign eof       = w_row_end & w_last_row;
    assign err_early = beat & ~tuser &  tlast & ~w_last_col;
    assign err_late  = beat & ~tuser & ~tlast &  w_last_col;
    assign err_sof   = w_restart & in_frame;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_restart) begin
            r_col <= DIM_WIDTH'(1);
            r_row <= '0;
        end else if (w_row_end) begin
            r_col <= '0;
            r_row <= r_row + DIM_WIDTH'(1);
        end else if (beat) begin
            r_col <= r_col + DIM_WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/median_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : median_frame_scheduler
//  Description : Frame-level controller in front of the 5x5 median pipeline.
//                Latches geometry, gates the AXI4-Stream input, injects flush
//                beats after each frame and keeps sticky status.
//  Ports       : i_clk, i_reset    - clock, synchronous active-high reset
//                i_enable          - run request
//                WIDTH, HEIGHT     - requested geometry
//                s_axis_tvalid/tuser/tlast, s_axis_tready - upstream stream
//                o_pipe_valid/sof/flush - beat qualifiers into the receiver
//                o_img_width/height - latched geometry
//                o_busy, o_frame_done, o_frame_count - progress status
//                o_err_cfg/early_eol/late_eol/sof - sticky error flags
//  Revision    : 1.0 - initial release
// ============================================================================
module median_frame_scheduler
    import median_sched_pkg::*;
#(
    parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
    parameter int DIM_WIDTH   = DIM_WIDTH_DEF,
    parameter int FLUSH_WIDTH = FLUSH_WIDTH_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic [DIM_WIDTH-1:0] WIDTH,
    input  logic [DIM_WIDTH-1:0] HEIGHT,
    input  logic                 s_axis_tvalid,
    input  logic                 s_axis_tuser,
    input  logic                 s_axis_tlast,
    output logic                 s_axis_tready,
    output logic                 o_pipe_valid,
    output logic                 o_pipe_sof,
    output logic                 o_pipe_flush,
    output logic [DIM_WIDTH-1:0] o_img_width,
    output logic [DIM_WIDTH-1:0] o_img_height,
    output logic                 o_busy,
    output logic                 o_frame_done,
    output logic [15:0]          o_frame_count,
    output logic                 o_err_cfg,
    output logic                 o_err_early_eol,
    output logic                 o_err_late_eol,
    output logic                 o_err_sof
);

    localparam int c_half = KERNEL_SIZE / 2;

    sched_state_t           r_state;
    logic                   r_ready;
    logic [DIM_WIDTH-1:0]   r_img_width;
    logic [DIM_WIDTH-1:0]   r_img_height;
    logic [FLUSH_WIDTH-1:0] r_flush_cnt;
    logic                   r_frame_done;
    logic [15:0]            r_frame_count;
    logic                   r_err_cfg;
    logic                   r_err_early;
    logic                   r_err_late;
    logic                   r_err_sof;

    logic                   w_accept;
    logic                   w_img_beat;
    logic                   w_flush_beat;
    logic                   w_cfg_ok;
    logic                   w_pos_eol;
    logic                   w_pos_eof;
    logic                   w_pos_err_early;
    logic                   w_pos_err_late;
    logic                   w_pos_err_sof;
    logic [FLUSH_WIDTH-1:0] w_flush_load;

    // Forwarding is purely combinational so pixel data can bypass the block.
    assign w_accept     = s_axis_tvalid & r_ready;
    assign w_img_beat   = w_accept & ((r_state == ST_RUN) |
                                      ((r_state == ST_WAIT_SOF) & s_axis_tuser));
    assign w_flush_beat = (r_state == ST_FLUSH);
    assign w_cfg_ok     = (WIDTH  >= DIM_WIDTH'(KERNEL_SIZE)) &
                          (HEIGHT >= DIM_WIDTH'(KERNEL_SIZE));
    // Counter runs from N-1 down to 0, giving exactly N flush cycles.
    assign w_flush_load = FLUSH_WIDTH'(flush_beats(32'(r_img_width), c_half))
                          - FLUSH_WIDTH'(1);

    median_frame_position #(
        .DIM_WIDTH (DIM_WIDTH)
    ) u_position (
        .clk        (i_clk),
        .rst        (i_reset),
        .beat       (w_img_beat),
        .in_frame   (r_state == ST_RUN),
        .tuser      (s_axis_tuser),
        .tlast      (s_axis_tlast),
        .img_width  (r_img_width),
        .img_height (r_img_height),
        .eol        (w_pos_eol),
        .eof        (w_pos_eof),
        .err_early  (w_pos_err_early),
        .err_late   (w_pos_err_late),
        .err_sof    (w_pos_err_sof)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_ready       <= 1'b0;
            r_img_width   <= '0;
            r_img_height  <= '0;
            r_flush_cnt   <= '0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
            r_err_cfg     <= 1'b0;
            r_err_early   <= 1'b0;
            r_err_late    <= 1'b0;
            r_err_sof     <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_pos_err_early) r_err_early <= 1'b1;
            if (w_pos_err_late)  r_err_late  <= 1'b1;
            if (w_pos_err_sof)   r_err_sof   <= 1'b1;

            // r_ready always tracks the state being entered, so tready is
            // high exactly while the FSM sits in WAIT_SOF or RUN.
            case (r_state)
                ST_IDLE: begin
                    if (i_enable) begin
                        r_img_width  <= WIDTH;
                        r_img_height <= HEIGHT;
                        if (w_cfg_ok) begin
                            r_state <= ST_WAIT_SOF;
                            r_ready <= 1'b1;
                        end else begin
                            r_err_cfg <= 1'b1;
                        end
                    end
                end
                ST_WAIT_SOF: begin
                    if (w_img_beat) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // eof can only assert together with a row end.
                    if (w_pos_eol && w_pos_eof) begin
                        r_state     <= ST_FLUSH;
                        r_ready     <= 1'b0;
                        r_flush_cnt <= w_flush_load;
                    end
                end
                ST_FLUSH: begin
                    if (r_flush_cnt == '0) begin
                        r_frame_done  <= 1'b1;
                        r_frame_count <= r_frame_count + 16'd1;
                        if (i_enable) begin
                            r_img_width  <= WIDTH;
                            r_img_height <= HEIGHT;
                            if (w_cfg_ok) begin
                                r_state <= ST_WAIT_SOF;
                                r_ready <= 1'b1;
                            end else begin
                                r_state   <= ST_IDLE;
                                r_err_cfg <= 1'b1;
                            end
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_flush_cnt <= r_flush_cnt - FLUSH_WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign s_axis_tready   = r_ready;
    assign o_pipe_valid    = w_img_beat | w_flush_beat;
    assign o_pipe_sof      = w_img_beat & s_axis_tuser;
    assign o_pipe_flush    = w_flush_beat;
    assign o_img_width     = r_img_width;
    assign o_img_height    = r_img_height;
    assign o_busy          = (r_state != ST_IDLE);
    assign o_frame_done    = r_frame_done;
    assign o_frame_count   = r_frame_count;
    assign o_err_cfg       = r_err_cfg;
    assign o_err_early_eol = r_err_early;
    assign o_err_late_eol  = r_err_late;
    assign o_err_sof       = r_err_sof;

endmodule
`default_nettype wire
